// File: rtl/fwd_operand_stage.sv
// ID/EX operand resolution with priority forwarding,
// load-use stall detection and a single-entry output slot.
module fwd_operand_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int NUM_OPS         = 2,
  parameter int NUM_FWD         = 2,
  parameter logic [DATA_WIDTH-1:0] PC_ADDR = 32'h8000_0000,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_pc,
  input  logic [NUM_OPS*REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [NUM_OPS*DATA_WIDTH-1:0]     in_rs_data,
  input  logic [NUM_OPS-1:0]                in_alt_sel,
  input  logic [NUM_OPS*DATA_WIDTH-1:0]     in_alt_data,
  input  logic [NUM_FWD-1:0]                fwd_we,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
  input  logic [NUM_FWD-1:0]                fwd_is_load,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_OPS*DATA_WIDTH-1:0]     out_op,
  output logic [DATA_WIDTH-1:0]             out_pc,
  output logic [STALL_CNT_WIDTH-1:0]        stall_cnt
);

  localparam int DW  = DATA_WIDTH;
  localparam int RAW = REG_ADDR_WIDTH;
  localparam int SCW = STALL_CNT_WIDTH;

  logic [NUM_OPS*DW-1:0] op_res;
  logic [NUM_OPS-1:0]    hz;
  logic                  hazard;
  logic                  accept;

  logic                  out_valid_q, out_valid_d;
  logic [NUM_OPS*DW-1:0] out_op_q, out_op_d;
  logic [DW-1:0]         out_pc_q, out_pc_d;
  logic [SCW-1:0]        stall_q, stall_d;

  genvar k;
  for (k = 0; k < NUM_OPS; k++) begin : g_op
    logic [RAW-1:0] rs;
    logic [DW-1:0]  res;
    logic           hzk;
    logic           hit;

    assign rs = in_rs_addr[k*RAW +: RAW];

    // Resolve one operand; the youngest matching tap wins,
    // and a matching in-flight load blocks older taps.
    always_comb begin
      res = in_rs_data[k*DW +: DW];
      hzk = 1'b0;
      hit = 1'b0;
      if (in_alt_sel[k]) begin
        res = in_alt_data[k*DW +: DW];
      end else if (rs == '0) begin
        res = '0;
      end else begin
        for (int j = 0; j < NUM_FWD; j++) begin
          if (!hit && fwd_we[j] &&
              fwd_rd[j*RAW +: RAW] == rs) begin
            hit = 1'b1;
            if (fwd_is_load[j]) hzk = 1'b1;
            else res = fwd_data[j*DW +: DW];
          end
        end
      end
    end

    assign op_res[k*DW +: DW] = res;
    assign hz[k]              = hzk;
  end

  assign hazard   = in_valid && (|hz);
  assign in_ready = !flush && !hazard &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Slot occupancy: flush kills, accept refills,
  // a consume without refill empties.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)                  out_valid_d = 1'b0;
    else if (accept)            out_valid_d = 1'b1;
    else if (out_ready)         out_valid_d = 1'b0;
  end

  // Payload only moves on accept to keep EX inputs quiet.
  always_comb begin
    out_op_d = out_op_q;
    out_pc_d = out_pc_q;
    if (accept) begin
      out_op_d = op_res;
      out_pc_d = in_pc;
    end
  end

  // Saturating count of load-use stall cycles.
  always_comb begin
    stall_d = stall_q;
    if (hazard && !flush && stall_q != '1)
      stall_d = stall_q + SCW'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_pc_q    <= PC_ADDR;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_pc_q    <= out_pc_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_pc    = out_pc_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Bench for fwd_operand_stage: directed plan steps
// followed by random traffic against a reference model.
module tb_fwd_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  alt_sel;
  logic [63:0] alt_data;
  logic [1:0]  fwe;
  logic [9:0]  frd;
  logic [63:0] fdata;
  logic [1:0]  fload;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_op;
  logic [31:0] out_pc;
  logic [3:0]  stall_cnt;

  int tests = 0;
  int fails = 0;

  logic        m_valid;
  logic [63:0] m_op;
  logic [31:0] m_pc;
  int          m_cnt;

  fwd_operand_stage #(.STALL_CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs_addr(rs_addr),
    .in_rs_data(rs_data), .in_alt_sel(alt_sel),
    .in_alt_data(alt_data), .fwd_we(fwe),
    .fwd_rd(frd), .fwd_data(fdata),
    .fwd_is_load(fload), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Reference resolve: first alt, then x0, then the first
  // (youngest) tap naming the register, then the regfile.
  function automatic void resolve(
      output logic [63:0] ops, output logic hzo);
    logic [4:0]  rs;
    logic [31:0] v;
    logic        found;
    ops = '0;
    hzo = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rs = rs_addr[k*5 +: 5];
      if (alt_sel[k]) v = alt_data[k*32 +: 32];
      else if (rs == 5'd0) v = 32'd0;
      else begin
        v = rs_data[k*32 +: 32];
        found = 1'b0;
        for (int j = 0; j < 2; j++)
          if (!found && fwe[j] && frd[j*5 +: 5] == rs) begin
            found = 1'b1;
            if (fload[j]) hzo = 1'b1;
            else v = fdata[j*32 +: 32];
          end
      end
      ops[k*32 +: 32] = v;
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_op    = '0;
    m_pc    = 32'h8000_0000;
    m_cnt   = 0;
  endtask

  task automatic clear_in();
    in_valid = 0; in_pc = 0; rs_addr = 0;
    rs_data = 0; alt_sel = 0; alt_data = 0;
    fwe = 0; frd = 0; fdata = 0; fload = 0;
    flush = 0;
  endtask

  // One clock: check in_ready, advance model, check outputs.
  task automatic step();
    logic [63:0] eops;
    logic        ehz, erdy, acc;
    #1;
    resolve(eops, ehz);
    ehz  = ehz && in_valid;
    erdy = !flush && !ehz && (!m_valid || out_ready);
    acc  = in_valid && erdy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, erdy});
    @(posedge clk);
    if (ehz && !flush && m_cnt < 15) m_cnt++;
    if (acc) begin
      m_op = eops;
      m_pc = in_pc;
    end
    if (flush) m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("stall_cnt", {60'd0, stall_cnt}, m_cnt);
    if (m_valid) begin
      chk("out_op", out_op, m_op);
      chk("out_pc", {32'd0, out_pc}, {32'd0, m_pc});
    end
  endtask

  initial begin
    clear_in();
    out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_op", out_op, 64'd0);
    chk("rst_pc", {32'd0, out_pc}, 64'h8000_0000);
    chk("rst_cnt", {60'd0, stall_cnt}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // youngest tap wins
    in_valid = 1; in_pc = 32'h100;
    rs_addr = {5'd0, 5'd5};
    fwe = 2'b11; frd = {5'd5, 5'd5};
    fdata = {32'h22, 32'h11};
    step();
    chk("fwd_prio", {32'd0, out_op[31:0]}, 64'h11);

    // x0 ignores a tap writing x0
    in_pc = 32'h104;
    rs_addr = {5'd3, 5'd0}; rs_data = {32'h33, 32'h44};
    fwe = 2'b01; frd = {5'd0, 5'd0};
    fdata = {32'h0, 32'hFF};
    step();
    chk("x0", {32'd0, out_op[31:0]}, 64'd0);

    // alt source beats a matching tap
    in_pc = 32'h108;
    rs_addr = {5'd9, 5'd0}; alt_sel = 2'b10;
    alt_data = {32'h8000_0004, 32'h0};
    frd = {5'd0, 5'd9}; fdata = {32'h0, 32'h99};
    step();
    chk("alt", {32'd0, out_op[63:32]}, 64'h8000_0004);
    alt_sel = 0;

    // load-use stall for three cycles
    in_pc = 32'h10C;
    rs_addr = {5'd7, 5'd0};
    fwe = 2'b01; frd = {5'd0, 5'd7}; fload = 2'b01;
    repeat (3) step();
    chk("stall3", {60'd0, stall_cnt}, 64'd3);
    fload = 0; fdata = {32'h0, 32'hABCD};
    step();
    chk("load_done", {32'd0, out_op[63:32]}, 64'hABCD);

    // backpressure holds the slot
    out_ready = 0; fwe = 0;
    in_pc = 32'h110;
    rs_addr = {5'd4, 5'd2}; rs_data = {32'h4444, 32'h2222};
    repeat (4) step();
    chk("bp_hold", {32'd0, out_op[63:32]}, 64'hABCD);
    out_ready = 1;
    step();
    chk("bp_release", out_op, {32'h4444, 32'h2222});
    chk("bp_valid", {63'd0, out_valid}, 64'd1);

    // flush kills the slot and blocks acceptance
    flush = 1;
    step();
    chk("flush", {63'd0, out_valid}, 64'd0);
    flush = 0;

    // counter saturation
    rs_addr = {5'd0, 5'd6};
    fwe = 2'b10; frd = {5'd6, 5'd0}; fload = 2'b10;
    repeat (20) step();
    chk("sat", {60'd0, stall_cnt}, 64'd15);

    // older valid tap does not bypass younger load
    fwe = 2'b11; frd = {5'd6, 5'd6};
    fload = 2'b01; fdata = {32'h66, 32'h0};
    step();
    chk("young_load", {63'd0, out_valid}, 64'd0);

    // fill slot, hold it, then reset asynchronously
    fwe = 0; fload = 0; in_pc = 32'h200;
    out_ready = 0;
    step();
    in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_pc", {32'd0, out_pc}, 64'h8000_0000);
    chk("arst_cnt", {60'd0, stall_cnt}, 64'd0);
    model_reset();
    #2 rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) < 3);
      flush     = ($urandom_range(0, 9) == 0);
      in_pc     = $urandom;
      rs_addr   = {2'b0, 3'($urandom_range(0, 7)),
                   2'b0, 3'($urandom_range(0, 7))};
      frd       = {2'b0, 3'($urandom_range(0, 7)),
                   2'b0, 3'($urandom_range(0, 7))};
      rs_data   = {$urandom, $urandom};
      alt_data  = {$urandom, $urandom};
      fdata     = {$urandom, $urandom};
      alt_sel   = 2'($urandom_range(0, 3)) &
                  2'($urandom_range(0, 3));
      fwe       = 2'($urandom_range(0, 3));
      fload     = {($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0)};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
